// File: rtl/fht_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fht_pkg : shared loader state encoding and frame-size helper             |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fht_pkg;

  localparam int NUM_BANKS = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    FIRE      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } fht_state_t;

  // Points per frame: four banks of 2^a_bit words each.
  function automatic int frame_len(input int a_bit);
    return NUM_BANKS << a_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fht_bitrev.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fht_bitrev : combinational bit reversal over W bits                      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fht_bitrev #(
  parameter int W = 11
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bit
      assign dout[i] = din[W-1-i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fht_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fht_loader : streams natural-order samples into four bit-reversed banks  |
// | and hands the frame to fht_control. rev 1.0                              |
// +--------------------------------------------------------------------------+
module fht_loader
  import fht_pkg::*;
#(
  parameter int A_BIT = 9,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iEN,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic [3:0]       oWE,
  output logic             oSTART,
  input  logic             iFHT_RDY,
  output logic             oBUSY
);

  localparam int              CW   = A_BIT + 2;
  localparam logic [CW-1:0]   LAST = CW'(frame_len(A_BIT) - 1);

  fht_state_t      state, state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_rev;
  logic            xfer;

  fht_bitrev #(.W(CW)) u_bitrev (
    .din  (cnt),
    .dout (cnt_rev)
  );

  // oREADY is a registered copy of (state == LOAD), so it doubles as the qualifier.
  assign xfer = oREADY & iVALID;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (iEN)                 state_next = LOAD;
      LOAD:      if (xfer && cnt == LAST) state_next = FIRE;
      FIRE:                               state_next = WAIT_BUSY;
      WAIT_BUSY: if (!iFHT_RDY)           state_next = WAIT_DONE;
      WAIT_DONE: if (iFHT_RDY)            state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oREADY <= 1'b0;
      oBUSY  <= 1'b0;
      oSTART <= 1'b0;
    end else begin
      oREADY <= (state_next == LOAD);
      oBUSY  <= (state_next != IDLE);
      oSTART <= (state == FIRE);
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      cnt      <= '0;
      oWE      <= 4'b0000;
      oADDR_WR <= '0;
      oDATA_WR <= '0;
    end else begin
      oWE <= 4'b0000;
      if (xfer) begin
        cnt      <= cnt + CW'(1);
        oWE      <= 4'b0001 << cnt_rev[CW-1:A_BIT];
        oADDR_WR <= cnt_rev[A_BIT-1:0];
        oDATA_WR <= iDATA;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fht_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_fht_loader : scoreboard bench for fht_loader at A_BIT=4 (N=64)        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fht_loader;

  localparam int A_BIT = 4;
  localparam int D_BIT = 16;
  localparam int N     = 64;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             en      = 1'b0;
  logic             valid   = 1'b0;
  logic             fht_rdy = 1'b1;
  logic [D_BIT-1:0] data    = '0;

  logic             ready;
  logic [A_BIT-1:0] addr_wr;
  logic [D_BIT-1:0] data_wr;
  logic [3:0]       we;
  logic             start;
  logic             busy;

  fht_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK     (clk),
    .iRESET   (rst_n),
    .iEN      (en),
    .iDATA    (data),
    .iVALID   (valid),
    .oREADY   (ready),
    .oADDR_WR (addr_wr),
    .oDATA_WR (data_wr),
    .oWE      (we),
    .oSTART   (start),
    .iFHT_RDY (fht_rdy),
    .oBUSY    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       we;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] data;
    int               cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks      = 0;
  int  errors      = 0;
  int  cyc         = 0;
  int  last_we_cyc = -1;
  int  start_cyc   = -1;
  int  start_count = 0;
  int  m_n         = 0;
  bit  track       = 1'b0;
  int  wr_map[4][16];

  logic [3:0]       hand_we[5]   = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
  logic [A_BIT-1:0] hand_addr[5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd8};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  function automatic int we_idx(input logic [3:0] w);
    case (w)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      default: return 3;
    endcase
  endfunction

  // Monitor: pops one expectation per observed bank write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (start) begin
      start_count++;
      start_cyc = cyc;
    end
    if (we != 4'b0000) begin
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_we",      32'(we),      32'(e.we));
        chk("wr_addr",    32'(addr_wr), 32'(e.addr));
        chk("wr_data",    32'(data_wr), 32'(e.data));
        chk("wr_latency", 32'(cyc),     32'(e.cyc));
      end
      if (track) wr_map[we_idx(we)][addr_wr]++;
    end
  end

  task automatic push_exp(input logic [D_BIT-1:0] d);
    wr_t        e;
    logic [5:0] r;
    if (m_n < 5) begin
      e.we   = hand_we[m_n];
      e.addr = hand_addr[m_n];
    end else begin
      r      = rev6(6'(m_n));
      e.we   = 4'b0001 << r[5:4];
      e.addr = r[3:0];
    end
    e.data = d;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    m_n = (m_n + 1) % N;
  endtask

  task automatic send(input logic [D_BIT-1:0] d, input int max_gap);
    int g;
    bit acc;
    g   = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    acc = 1'b0;
    for (int i = 0; i < g; i++) begin
      @(negedge clk); valid = 1'b0;
      @(posedge clk);
    end
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = d;
      if (ready) begin
        push_exp(d);
        acc = 1'b1;
      end
      @(posedge clk);
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready),   32'd0);
    chk({tag, "_we"},    32'(we),      32'd0);
    chk({tag, "_start"}, 32'(start),   32'd0);
    chk({tag, "_busy"},  32'(busy),    32'd0);
    chk({tag, "_addr"},  32'(addr_wr), 32'd0);
    chk({tag, "_data"},  32'(data_wr), 32'd0);
  endtask

  initial begin
    int bad;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) wr_map[b][a] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;

    // Frame 1: first five back-to-back, then random valid gaps.
    track = 1'b1;
    for (int i = 0; i < N; i++) send(16'hA000 + 16'(i), (i < 5) ? 0 : 2);
    @(negedge clk);
    chk("ready_after_last", 32'(ready), 32'd0);
    valid = 1'b1;
    data  = 16'hDEAD;

    for (int t = 0; t < 10 && start_count == 0; t++) begin
      @(negedge clk); #1;
    end
    chk("start_count",   32'(start_count), 32'd1);
    chk("start_latency", 32'(start_cyc),   32'(last_we_cyc + 1));
    fht_rdy = 1'b0;
    @(negedge clk);
    chk("start_width", 32'(start), 32'd0);

    for (int i = 0; i < 20; i++) begin
      if (i == 10) en = 1'b0;
      if (i % 5 == 0) begin
        chk("wait_ready", 32'(ready), 32'd0);
        chk("wait_busy",  32'(busy),  32'd1);
      end
      @(negedge clk);
    end
    chk("busy_before_rdy", 32'(busy), 32'd1);
    fht_rdy = 1'b1;
    @(negedge clk);
    chk("busy_after_rdy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold_ready", 32'(ready), 32'd0);
      chk("idle_hold_busy",  32'(busy),  32'd0);
    end
    track = 1'b0;
    bad   = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++)
        if (wr_map[b][a] != 1) bad++;
    chk("frame_coverage", 32'(bad), 32'd0);
    chk("single_start",   32'(start_count), 32'd1);

    // Frame 2: abort with reset after 30 samples.
    valid = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 30; i++) send(16'h5000 + 16'(i), 1);
    @(negedge clk); #1;
    chk("drain_before_reset", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    m_n   = 0;

    // Frame 3: restarts at n=0.
    for (int i = 0; i < 5; i++) send(16'h3000 + 16'(i), 0);
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("no_spurious_start", 32'(start_count), 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame3_busy",       32'(busy),         32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fht_loader.md
FHT_LOADER -- requirements
Module: fht_loader

Interface
REQ-001 Parameter A_BIT, default 9: bank address width; frame length N = 4*2^A_BIT points.
REQ-002 Parameter D_BIT, default 16: sample width.
REQ-003 iCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 iRESET  input  1  asynchronous, active-low reset.
REQ-005 iEN  input  1  level; permits leaving IDLE.
REQ-006 iDATA  input  D_BIT  input sample, natural order.
REQ-007 iVALID  input  1  iDATA valid.
REQ-008 oREADY  output  1  loader accepts a sample this cycle.
REQ-009 oADDR_WR  output  A_BIT  bank write address.
REQ-010 oDATA_WR  output  D_BIT  bank write data.
REQ-011 oWE  output  4  one-hot bank write enables, bank 0..3.
REQ-012 oSTART  output  1  one-cycle start pulse to fht_control iSTART.
REQ-013 iFHT_RDY  input  1  fht_control oRDY: high idle, low while converting.
REQ-014 oBUSY  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, LOAD, FIRE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE -> LOAD when iEN=1; otherwise hold.
REQ-017 oREADY SHALL be 1 only in LOAD; a transfer occurs on a rising edge with iVALID=1 and oREADY=1.
REQ-018 Sample counter n (A_BIT+2 bits) SHALL reset to 0 and increment on each transfer; no increment without transfer.
REQ-019 r = bit-reverse of n over A_BIT+2 bits; bank = r[A_BIT+1:A_BIT], address = r[A_BIT-1:0].
REQ-020 Write latency 1: for a transfer at edge k, oWE[bank]=1 with oADDR_WR, oDATA_WR during the cycle after edge k; oWE=0 when no transfer.
REQ-021 Transfer with n=N-1: n wraps to 0 and state goes LOAD -> FIRE at the same edge.
REQ-022 FIRE lasts exactly one cycle, coinciding with the last write cycle.
REQ-023 oSTART SHALL be 1 for exactly the single cycle following FIRE, registered; state is WAIT_BUSY during it.
REQ-024 WAIT_BUSY -> WAIT_DONE when iFHT_RDY=0; WAIT_DONE -> IDLE when iFHT_RDY=1.
REQ-025 No sample is accepted from the last transfer of a frame until IDLE -> LOAD of the next frame (banks are owned by fht_control).
REQ-026 iEN deassertion in LOAD, FIRE or WAIT_* SHALL not abort the frame; it only blocks IDLE -> LOAD.
REQ-027 iVALID toggling mid-frame (gaps) SHALL not disturb n or addressing.

Reset
REQ-028 iRESET=0 SHALL asynchronously force state IDLE, n=0, oREADY=0, oWE=0, oSTART=0, oBUSY=0, oADDR_WR=0, oDATA_WR=0.
REQ-029 Reset mid-frame SHALL discard partial frame; next frame restarts at n=0 with no oSTART issued.

Structure
REQ-030 State enum and N-from-A_BIT function SHALL live in shared package fht_pkg.
REQ-031 Bit reversal SHALL be a parameterised combinational sub-module fht_bitrev (width A_BIT+2).
REQ-032 All outputs SHALL be driven from registers.

Verification (bench A_BIT=4, N=64)
REQ-033 Reset release, iEN=1, samples n=0..4 back-to-back -> oWE/addr: n0 bank0 addr0; n1 bank2 addr0; n2 bank1 addr0; n3 bank3 addr0; n4 bank0 addr8, each one cycle after transfer.
REQ-034 Full 64-sample frame with random iVALID gaps -> every (bank,addr) written exactly once, data matches bit-reversed reference, oREADY=0 after sample 63.
REQ-035 After last write -> oSTART one cycle high exactly 1 cycle after last oWE; model iFHT_RDY low 20 cycles then high -> oBUSY drops 1 cycle after iFHT_RDY rises.
REQ-036 iVALID=1 held during WAIT_BUSY/WAIT_DONE -> no transfer, oWE=0 throughout.
REQ-037 iRESET=0 after 30 samples -> all outputs 0 immediately; new frame starts writing n0 at bank0 addr0, no spurious oSTART.
REQ-038 iEN=0 in WAIT_DONE -> loader stays IDLE after iFHT_RDY=1 until iEN=1, oREADY=0 meanwhile.
